// File: rtl/processor_pkg.sv
// Shared definitions for the 18-bit in-order pipeline: opcodes, ALU and condition codes,
// and code-word field positions used by stages 2 and 3.
package processor_pkg;

    localparam int ADDR_SIZE = 18;
    localparam int WORD_SIZE = 18;

    // Code-word layout: [17:14] op, [13:11] rx, [10:8] ry/cond, [7:0] imm8
    localparam int OP_MSB   = 17;
    localparam int OP_LSB   = 14;
    localparam int RX_MSB   = 13;
    localparam int RX_LSB   = 11;
    localparam int RY_MSB   = 10;
    localparam int RY_LSB   = 8;
    localparam int IMM8_MSB = 7;

    typedef enum logic [3:0] {
        OP_ALU                = 4'd0,
        OP_MUL_SHIFT          = 4'd1,
        OP_REG_ADD_IMM8       = 4'd2,
        OP_REG_MOV_IMM11      = 4'd3,
        OP_REG_MOV_IMM11_TOP  = 4'd4,
        OP_LOAD_FROM_MEMORY   = 4'd5,
        OP_WRITE_TO_MEMORY    = 4'd6,
        OP_IF                 = 4'd7,
        OP_CALL_IMM14         = 4'd8,
        OP_RETURN             = 4'd9,
        OP_WAIT               = 4'd10
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_t;

    // Codes 5-7 are "never".
    typedef enum logic [2:0] {
        COND_ZERO     = 3'd0,
        COND_NONZERO  = 3'd1,
        COND_NEGATIVE = 3'd2,
        COND_NONNEG   = 3'd3,
        COND_ALWAYS   = 3'd4
    } cond_t;

endpackage

// File: rtl/processor_alu.sv
// Combinational ALU for stage 3: eight logic/arithmetic ops plus the signed
// multiply-then-arithmetic-shift used by OP_MUL_SHIFT.
module processor_alu
    import processor_pkg::*;
#(
    parameter int WORD_SIZE = 18
) (
    input  logic                 mul_select,
    input  alu_op_t              op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic [4:0]           shift,
    output logic [WORD_SIZE-1:0] result
);

    logic signed [2*WORD_SIZE-1:0] product;
    logic [4:0]                    shift_amount;

    assign product      = $signed(a) * $signed(b);
    assign shift_amount = b[4:0];

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        result = '0;
        if (mul_select) begin
            result = WORD_SIZE'(product >>> shift);
        end else begin
            case (op)
                ALU_ADD: result = a + b;
                ALU_SUB: result = a - b;
                ALU_AND: result = a & b;
                ALU_OR:  result = a | b;
                ALU_XOR: result = a ^ b;
                ALU_NOT: result = ~b;
                ALU_SHL: result = (int'(shift_amount) >= WORD_SIZE) ? '0 : a << shift_amount;
                ALU_SHR: result = (int'(shift_amount) >= WORD_SIZE) ? '0 : a >> shift_amount;
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/processor_stage3.sv
// Execute/writeback stage: result mux, register-file write port, branch resolution
// and the kill counter that discards wrong-path instructions after a taken jump.
module processor_stage3
    import processor_pkg::*;
#(
    parameter int ADDR_SIZE  = 18,
    parameter int WORD_SIZE  = 18,
    parameter int KILL_SLOTS = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 no_operation,
    input  logic [WORD_SIZE-1:0] alu_data0,
    input  logic [WORD_SIZE-1:0] alu_data1,
    input  logic [17:0]          code_word,
    input  logic [ADDR_SIZE-1:0] ip,
    input  logic [ADDR_SIZE-1:0] ip_plus_one,
    input  logic [ADDR_SIZE-1:0] data1_plus_imm8,
    input  logic [WORD_SIZE-1:0] memory_out,
    output logic                 reg_write_enable,
    output logic [2:0]           reg_write_addr,
    output logic [WORD_SIZE-1:0] reg_write_data,
    output logic                 jump_enable,
    output logic [ADDR_SIZE-1:0] jump_addr,
    output logic                 retired
);

    logic [1:0]           kill_cnt;
    logic                 valid;
    logic                 cond_true;
    logic [WORD_SIZE-1:0] alu_result;
    opcode_t              op;
    logic                 unused_inputs;

    // ip/ip_plus_one are consumed by stage 2 (call return address); not needed here.
    assign unused_inputs = ^{ip, ip_plus_one};

    assign op    = opcode_t'(code_word[OP_MSB:OP_LSB]);
    assign valid = !reset && !no_operation && (kill_cnt == 2'd0);

    processor_alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
        .mul_select (op == OP_MUL_SHIFT),
        .op         (alu_op_t'(code_word[2:0])),
        .a          (alu_data0),
        .b          (alu_data1),
        .shift      (code_word[4:0]),
        .result     (alu_result)
    );

    always_comb begin
        cond_true = 1'b0;
        case (cond_t'(code_word[RY_MSB:RY_LSB]))
            COND_ZERO:     cond_true = (alu_data0 == '0);
            COND_NONZERO:  cond_true = (alu_data0 != '0);
            COND_NEGATIVE: cond_true = alu_data0[WORD_SIZE-1];
            COND_NONNEG:   cond_true = !alu_data0[WORD_SIZE-1];
            COND_ALWAYS:   cond_true = 1'b1;
            default:       cond_true = 1'b0;
        endcase
    end

    always_comb begin
        reg_write_enable = 1'b0;
        reg_write_addr   = '0;
        reg_write_data   = '0;
        jump_enable      = 1'b0;
        jump_addr        = '0;
        retired          = 1'b0;
        if (valid) begin
            retired = 1'b1;
            case (op)
                OP_ALU, OP_MUL_SHIFT, OP_REG_ADD_IMM8, OP_REG_MOV_IMM11,
                OP_REG_MOV_IMM11_TOP, OP_LOAD_FROM_MEMORY: begin
                    reg_write_enable = 1'b1;
                    reg_write_addr   = code_word[RX_MSB:RX_LSB];
                end
                default: ;
            endcase
            case (op)
                OP_ALU, OP_MUL_SHIFT: reg_write_data = alu_result;
                OP_REG_ADD_IMM8:      reg_write_data = data1_plus_imm8;
                OP_REG_MOV_IMM11:     reg_write_data = {{(WORD_SIZE-11){1'b0}}, code_word[10:0]};
                OP_REG_MOV_IMM11_TOP: reg_write_data = {code_word[10:0], {(WORD_SIZE-11){1'b0}}};
                OP_LOAD_FROM_MEMORY:  reg_write_data = memory_out;
                OP_IF: begin
                    jump_enable = cond_true;
                    jump_addr   = cond_true ? data1_plus_imm8 : '0;
                end
                OP_CALL_IMM14: begin
                    jump_enable = 1'b1;
                    jump_addr   = {{(ADDR_SIZE-14){1'b0}}, code_word[13:0]};
                end
                OP_RETURN: begin
                    jump_enable = 1'b1;
                    jump_addr   = memory_out;
                end
                default: ;
            endcase
        end
    end

    // Bubbles leave the counter alone so only real wrong-path instructions use up slots.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            kill_cnt <= 2'd0;
        end else if (jump_enable) begin
            kill_cnt <= 2'(KILL_SLOTS);
        end else if (kill_cnt != 2'd0 && !no_operation) begin
            kill_cnt <= kill_cnt - 2'd1;
        end
    end

endmodule

// File: tb/tb_processor_stage3.sv
// Self-checking bench for processor_stage3: directed scenarios with fixed expected values
// plus randomized instruction streams checked against a behavioural model.
module tb_processor_stage3;
    import processor_pkg::*;

    localparam int  KILL = 1;
    localparam longint MASK = 64'h3FFFF;

    logic        clock = 1'b0;
    logic        reset;
    logic        no_operation;
    logic [17:0] alu_data0, alu_data1, code_word, ip, ip_plus_one, data1_plus_imm8, memory_out;
    logic        reg_write_enable, jump_enable, retired;
    logic [2:0]  reg_write_addr;
    logic [17:0] reg_write_data, jump_addr;

    typedef struct packed {
        logic        ret;
        logic        we;
        logic [2:0]  wa;
        logic [17:0] wd;
        logic        je;
        logic [17:0] ja;
    } out_t;

    out_t got, exp_o;
    int   checks = 0;
    int   errors = 0;
    int   model_kill = 0;

    assign got = '{ret: retired, we: reg_write_enable, wa: reg_write_addr,
                   wd: reg_write_data, je: jump_enable, ja: jump_addr};

    processor_stage3 dut (
        .clock            (clock),
        .reset            (reset),
        .no_operation     (no_operation),
        .alu_data0        (alu_data0),
        .alu_data1        (alu_data1),
        .code_word        (code_word),
        .ip               (ip),
        .ip_plus_one      (ip_plus_one),
        .data1_plus_imm8  (data1_plus_imm8),
        .memory_out       (memory_out),
        .reg_write_enable (reg_write_enable),
        .reg_write_addr   (reg_write_addr),
        .reg_write_data   (reg_write_data),
        .jump_enable      (jump_enable),
        .jump_addr        (jump_addr),
        .retired          (retired)
    );

    always #5 clock = ~clock;

    function automatic logic [17:0] mk(input opcode_t op, input logic [2:0] rx,
                                       input logic [2:0] ry, input logic [7:0] imm);
        return {op, rx, ry, imm};
    endfunction

    function automatic longint sgn18(input logic [17:0] v);
        return (v >= 18'h20000) ? longint'(v) - 64'sh40000 : longint'(v);
    endfunction

    // Address/data fields only carry meaning while their strobe is high.
    function automatic out_t norm(input out_t o);
        out_t r = o;
        if (!r.we) begin r.wa = '0; r.wd = '0; end
        if (!r.je) r.ja = '0;
        return r;
    endfunction

    function automatic out_t model();
        out_t   r = '0;
        longint a = longint'(alu_data0);
        longint b = longint'(alu_data1);
        longint v = 0;
        int     sh;
        logic [2:0] f = code_word[2:0];
        if (reset || no_operation || model_kill != 0) return r;
        r.ret = 1'b1;
        r.wa  = code_word[13:11];
        case (opcode_t'(code_word[17:14]))
            OP_ALU: begin
                r.we = 1'b1;
                sh = int'(b % 32);
                case (f)
                    3'd0: v = a + b;
                    3'd1: v = a - b;
                    3'd2: v = a & b;
                    3'd3: v = a | b;
                    3'd4: v = a ^ b;
                    3'd5: v = ~b;
                    3'd6: v = (sh > 17) ? 0 : a << sh;
                    default: v = (sh > 17) ? 0 : a >> sh;
                endcase
                r.wd = 18'(v & MASK);
            end
            OP_MUL_SHIFT: begin
                r.we = 1'b1;
                v = (sgn18(alu_data0) * sgn18(alu_data1)) >>> code_word[4:0];
                r.wd = 18'(v & MASK);
            end
            OP_REG_ADD_IMM8:      begin r.we = 1'b1; r.wd = data1_plus_imm8; end
            OP_REG_MOV_IMM11:     begin r.we = 1'b1; r.wd = 18'(code_word[10:0]); end
            OP_REG_MOV_IMM11_TOP: begin r.we = 1'b1; r.wd = 18'((longint'(code_word[10:0]) * 128) & MASK); end
            OP_LOAD_FROM_MEMORY:  begin r.we = 1'b1; r.wd = memory_out; end
            OP_IF: begin
                case (code_word[10:8])
                    3'd0: r.je = (sgn18(alu_data0) == 0);
                    3'd1: r.je = (sgn18(alu_data0) != 0);
                    3'd2: r.je = (sgn18(alu_data0) < 0);
                    3'd3: r.je = (sgn18(alu_data0) >= 0);
                    3'd4: r.je = 1'b1;
                    default: r.je = 1'b0;
                endcase
                if (r.je) r.ja = data1_plus_imm8;
            end
            OP_CALL_IMM14: begin r.je = 1'b1; r.ja = 18'(code_word[13:0]); end
            OP_RETURN:     begin r.je = 1'b1; r.ja = memory_out; end
            default: ;
        endcase
        if (!r.we) r.wa = '0;
        return r;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic rst, input logic nop, input logic [17:0] cw,
                         input logic [17:0] a, input logic [17:0] b,
                         input logic [17:0] ipv, input logic [17:0] mem);
        @(negedge clock);
        reset           = rst;
        no_operation    = nop;
        code_word       = cw;
        alu_data0       = a;
        alu_data1       = b;
        ip              = ipv;
        ip_plus_one     = ipv + 18'd1;
        data1_plus_imm8 = 18'(longint'(b) + sgn18({{10{cw[7]}}, cw[7:0]}));
        memory_out      = mem;
        #1;
    endtask

    // Advance the reference kill count across the rising edge.
    task automatic tick(input logic taken);
        @(posedge clock);
        if (reset) model_kill = 0;
        else if (taken) model_kill = KILL;
        else if (model_kill > 0 && !no_operation) model_kill--;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, mk(OP_REG_ADD_IMM8, 3'd2, 3'd1, 8'h05), 18'h1, 18'h100, 18'h0, 18'h0);
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", got);
        end
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic test_add_alu_mul();
        drive(1'b0, 1'b0, mk(OP_REG_ADD_IMM8, 3'd2, 3'd1, 8'h05), 18'h0, 18'h00100, 18'h0, 18'h0);
        exp_o = '{ret: 1'b1, we: 1'b1, wa: 3'd2, wd: 18'h00105, je: 1'b0, ja: '0};
        checks++;
        if (norm(got) !== exp_o) begin errors++; $display("FAIL add_imm8 got %h want %h", got, exp_o); end
        tick(1'b0);

        drive(1'b0, 1'b0, mk(OP_ALU, 3'd3, 3'd4, 8'h01), 18'h00000, 18'h00001, 18'h0, 18'h0);
        exp_o = '{ret: 1'b1, we: 1'b1, wa: 3'd3, wd: 18'h3FFFF, je: 1'b0, ja: '0};
        checks++;
        if (norm(got) !== exp_o) begin errors++; $display("FAIL alu_sub got %h want %h", got, exp_o); end
        tick(1'b0);

        drive(1'b0, 1'b0, mk(OP_ALU, 3'd5, 3'd4, 8'h06), 18'h00001, 18'd20, 18'h0, 18'h0);
        exp_o = '{ret: 1'b1, we: 1'b1, wa: 3'd5, wd: 18'h00000, je: 1'b0, ja: '0};
        checks++;
        if (norm(got) !== exp_o) begin errors++; $display("FAIL alu_shl20 got %h want %h", got, exp_o); end
        tick(1'b0);

        drive(1'b0, 1'b0, mk(OP_MUL_SHIFT, 3'd7, 3'd1, 8'h01), 18'h3FFFD, 18'h00004, 18'h0, 18'h0);
        exp_o = '{ret: 1'b1, we: 1'b1, wa: 3'd7, wd: 18'h3FFFA, je: 1'b0, ja: '0};
        checks++;
        if (norm(got) !== exp_o) begin errors++; $display("FAIL mul_shift got %h want %h", got, exp_o); end
        tick(1'b0);
    endtask

    task automatic test_if_kill();
        drive(1'b0, 1'b0, mk(OP_IF, 3'd1, 3'd0, 8'hFE), 18'h0, 18'h00010, 18'h00010, 18'h0);
        exp_o = '{ret: 1'b1, we: 1'b0, wa: '0, wd: '0, je: 1'b1, ja: 18'h0000E};
        checks++;
        if (norm(got) !== exp_o) begin errors++; $display("FAIL if_taken got %h want %h", got, exp_o); end
        tick(1'b1);

        drive(1'b0, 1'b0, mk(OP_REG_ADD_IMM8, 3'd2, 3'd1, 8'h01), 18'h0, 18'h00011, 18'h11, 18'h0);
        checks++;
        if (got !== '0) begin errors++; $display("FAIL killed_after_if got %h want 0", got); end
        tick(1'b0);

        drive(1'b0, 1'b0, mk(OP_REG_ADD_IMM8, 3'd4, 3'd1, 8'h02), 18'h0, 18'h00020, 18'h0E, 18'h0);
        exp_o = '{ret: 1'b1, we: 1'b1, wa: 3'd4, wd: 18'h00022, je: 1'b0, ja: '0};
        checks++;
        if (norm(got) !== exp_o) begin errors++; $display("FAIL after_kill got %h want %h", got, exp_o); end
        tick(1'b0);
    endtask

    task automatic test_bubble_during_kill();
        drive(1'b0, 1'b0, mk(OP_IF, 3'd1, 3'd4, 8'h03), 18'h5, 18'h00040, 18'h00040, 18'h0);
        exp_o = '{ret: 1'b1, we: 1'b0, wa: '0, wd: '0, je: 1'b1, ja: 18'h00043};
        checks++;
        if (norm(got) !== exp_o) begin errors++; $display("FAIL if_always got %h want %h", got, exp_o); end
        tick(1'b1);

        drive(1'b0, 1'b1, mk(OP_REG_ADD_IMM8, 3'd2, 3'd1, 8'h01), 18'h0, 18'h1, 18'h0, 18'h0);
        checks++;
        if (got !== '0) begin errors++; $display("FAIL bubble got %h want 0", got); end
        tick(1'b0);

        drive(1'b0, 1'b0, mk(OP_REG_ADD_IMM8, 3'd2, 3'd1, 8'h01), 18'h0, 18'h1, 18'h0, 18'h0);
        checks++;
        if (got !== '0) begin errors++; $display("FAIL killed_after_bubble got %h want 0", got); end
        tick(1'b0);

        drive(1'b0, 1'b0, mk(OP_REG_MOV_IMM11, 3'd6, 3'd5, 8'h55), 18'h0, 18'h0, 18'h0, 18'h0);
        exp_o = '{ret: 1'b1, we: 1'b1, wa: 3'd6, wd: 18'h00555, je: 1'b0, ja: '0};
        checks++;
        if (norm(got) !== exp_o) begin errors++; $display("FAIL mov_imm11 got %h want %h", got, exp_o); end
        tick(1'b0);
    endtask

    task automatic test_call_return_reset();
        drive(1'b0, 1'b0, {OP_CALL_IMM14, 14'h1234}, 18'h0, 18'h0, 18'h00100, 18'h0);
        exp_o = '{ret: 1'b1, we: 1'b0, wa: '0, wd: '0, je: 1'b1, ja: 18'h01234};
        checks++;
        if (norm(got) !== exp_o) begin errors++; $display("FAIL call got %h want %h", got, exp_o); end
        tick(1'b1);

        drive(1'b0, 1'b0, mk(OP_WAIT, 3'd0, 3'd0, 8'h0), 18'h0, 18'h0, 18'h0, 18'h0);
        checks++;
        if (got !== '0) begin errors++; $display("FAIL killed_after_call got %h want 0", got); end
        tick(1'b0);

        drive(1'b0, 1'b0, mk(OP_RETURN, 3'd0, 3'd0, 8'h0), 18'h0, 18'h0, 18'h01234, 18'h00021);
        exp_o = '{ret: 1'b1, we: 1'b0, wa: '0, wd: '0, je: 1'b1, ja: 18'h00021};
        checks++;
        if (norm(got) !== exp_o) begin errors++; $display("FAIL return got %h want %h", got, exp_o); end
        tick(1'b1);

        drive(1'b1, 1'b0, mk(OP_LOAD_FROM_MEMORY, 3'd1, 3'd0, 8'h0), 18'h0, 18'h0, 18'h0, 18'h2ABCD);
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_mid_kill got %h want 0", got); end
        tick(1'b0);

        drive(1'b0, 1'b0, mk(OP_LOAD_FROM_MEMORY, 3'd1, 3'd0, 8'h0), 18'h0, 18'h0, 18'h0, 18'h2ABCD);
        exp_o = '{ret: 1'b1, we: 1'b1, wa: 3'd1, wd: 18'h2ABCD, je: 1'b0, ja: '0};
        checks++;
        if (norm(got) !== exp_o) begin errors++; $display("FAIL after_reset_load got %h want %h", got, exp_o); end
        tick(1'b0);
    endtask

    task automatic test_random(input int n);
        logic [17:0] cw, a, b, ipv;
        logic        nop, rst;
        for (int i = 0; i < n; i++) begin
            cw  = 18'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? 18'h0 : 18'($urandom);
            ipv = 18'($urandom);
            b   = (cw[17:14] == OP_IF) ? ipv : 18'($urandom);
            if (cw[17:14] == OP_ALU && $urandom_range(0, 1) == 1) b = 18'($urandom_range(0, 31));
            nop = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 49) == 0);
            drive(rst, nop, cw, a, b, ipv, 18'($urandom));
            exp_o = model();
            checks++;
            if (!exp_o.ret) begin
                if (got !== '0) begin
                    errors++;
                    $display("FAIL random_invalid[%0d] cw %h got %h want 0", i, cw, got);
                end
            end else if (norm(got) !== exp_o) begin
                errors++;
                $display("FAIL random[%0d] cw %h a %h b %h got %h want %h", i, cw, a, b, got, exp_o);
            end
            tick(exp_o.je);
        end
    endtask

    initial begin
        reset = 1'b1;
        no_operation = 1'b0;
        code_word = '0; alu_data0 = '0; alu_data1 = '0; ip = '0; ip_plus_one = '0;
        data1_plus_imm8 = '0; memory_out = '0;
        test_reset();
        test_add_alu_mul();
        test_if_kill();
        test_bubble_during_kill();
        test_call_return_reset();
        test_random(600);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
